// File: rtl/field_serializer.sv
// field_serializer: splits one wide word into narrow fields, LSB field first.
// Reports whether the word fits in one field; optionally sends one beat then.
module field_serializer #(
   parameter  int IN_W       = 32,
   parameter  int OUT_W      = 5,
   parameter  int TRUNC_MODE = 0,
   localparam int NUM_CHUNKS = (IN_W + OUT_W - 1) / OUT_W,
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             InValid,
   output logic             InReady,
   input  logic [IN_W-1:0]  InData,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [OUT_W-1:0] OutData,
   output logic [IDX_W-1:0] OutIdx,
   output logic             OutLast,
   output logic             Fits
);

   localparam int SH_W = NUM_CHUNKS * OUT_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_e;

   state_e            state_q, state_d;
   logic [SH_W-1:0]   shreg_q, shreg_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              fits_q, fits_d;

   // State and datapath registers; reset discards any word in flight.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         fits_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         fits_q  <= fits_d;
      end
   end

   // Next-state and handshake outputs: capture in IDLE, shift out in SEND.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      idx_d    = idx_q;
      fits_d   = fits_q;
      InReady  = 1'b0;
      OutValid = 1'b0;
      OutData  = '0;
      OutLast  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Gate with reset so nothing looks acceptable while held in reset.
            InReady = Rst_n;
            if (InValid) begin
               shreg_d = SH_W'(InData);
               fits_d  = ((InData >> OUT_W) == '0);
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            OutValid = 1'b1;
            OutData  = shreg_q[OUT_W-1:0];
            OutLast  = (idx_q == LAST_IDX) ||
                       ((TRUNC_MODE != 0) && fits_q);
            if (OutReady) begin
               if (OutLast) begin
                  state_d = IDLE;
               end else begin
                  shreg_d = shreg_q >> OUT_W;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
         end
      endcase
   end

   assign OutIdx = idx_q;
   assign Fits   = fits_q;

endmodule
